qspi_flash_responder: RTL and testbench

- Synthesizable SPI/QSPI flash target: the responder end of the link driven by qspi_flashmem.
- Decodes READ (0x03) and Quad I/O Fast Read (0xEB), including continuous-read mode.
- Serves data bytes from a synchronous memory port (SPRAM/BRAM image).
- Used as a flash stand-in for NES ROM emulation in simulation and FPGA loopback.
- SPI pins are oversampled in the system clock domain; clk must be at least 8x spi_sclk.

---
 rtl/qspi_flash_responder_if.sv | 26 ++
 rtl/qspi_flash_responder.sv | 204 ++++++++++++++++++++
 tb/tb_qspi_flash_responder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_flash_responder_if.sv
// Pin and memory-port bundle between a QSPI flash responder (slave) and
// the host side that drives the SPI link and serves the byte memory (master).
interface qspi_flash_responder_if #(
  parameter int ADDR_W = 24
);
  logic              spi_sclk;
  logic              spi_cs_n;
  logic [3:0]        io_in;
  logic [3:0]        io_out;
  logic [3:0]        io_oe;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              busy;
  logic              cont_mode;

  modport slave (
    input  spi_sclk, spi_cs_n, io_in, mem_rdata,
    output io_out, io_oe, mem_rd, mem_addr, busy, cont_mode
  );

  modport master (
    output spi_sclk, spi_cs_n, io_in, mem_rdata,
    input  io_out, io_oe, mem_rd, mem_addr, busy, cont_mode
  );
endinterface

// File: rtl/qspi_flash_responder.sv
// SPI/QSPI flash target answering READ (0x03) and Quad I/O Fast Read (0xEB),
// serving bytes from a synchronous memory; SPI pins oversampled in clk domain.
module qspi_flash_responder #(
  parameter int ADDR_W       = 24,
  parameter int DUMMY_CYCLES = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  qspi_flash_responder_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR_S, ADDR_Q, MODE, DUMMY, DATA_S, DATA_Q, IGNORE
  } state_t;

  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [3:0]             io_sync_q [SYNC_STAGES];
  logic                   sclk_prev_q;

  state_t            state_q;
  logic [7:0]        cnt_q;
  logic [23:0]       sr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        buf_q;
  logic [7:0]        sh_q;
  logic              rd_vld_q;
  logic              mem_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        io_out_q;
  logic [3:0]        io_oe_q;
  logic              cont_q;

  logic              sclk_s, cs_s, rise, fall;
  logic [3:0]        io_s;
  logic [23:0]       sr1_d, sr4_d;
  logic [ADDR_W-1:0] addr_inc_d;

  // cs_n resets to deasserted so busy reads 0 while in reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) io_sync_q[i] <= '0;
    end else begin
      sclk_sync_q[0] <= bus.spi_sclk;
      cs_sync_q[0]   <= bus.spi_cs_n;
      io_sync_q[0]   <= bus.io_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        cs_sync_q[i]   <= cs_sync_q[i-1];
        io_sync_q[i]   <= io_sync_q[i-1];
      end
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    cs_s       = cs_sync_q[SYNC_STAGES-1];
    io_s       = io_sync_q[SYNC_STAGES-1];
    rise       = sclk_s & ~sclk_prev_q;
    fall       = ~sclk_s & sclk_prev_q;
    sr1_d      = {sr_q[22:0], io_s[0]};
    sr4_d      = {sr_q[19:0], io_s};
    addr_inc_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      addr_q     <= '0;
      buf_q      <= '0;
      sh_q       <= '0;
      rd_vld_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      io_out_q   <= '0;
      io_oe_q    <= '0;
      cont_q     <= 1'b0;
    end else begin
      mem_rd_q <= 1'b0;
      rd_vld_q <= mem_rd_q;
      if (rd_vld_q) buf_q <= bus.mem_rdata;

      // Deselect outranks any sclk edge seen in the same clk
      if (cs_s) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        io_oe_q  <= '0;
        io_out_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            cnt_q   <= '0;
            state_q <= cont_q ? ADDR_Q : CMD;
          end
          CMD: if (rise) begin
            sr_q  <= sr1_d;
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == 8'd7) begin
              cnt_q <= '0;
              if (sr1_d[7:0] == 8'h03)      state_q <= ADDR_S;
              else if (sr1_d[7:0] == 8'hEB) state_q <= ADDR_Q;
              else                          state_q <= IGNORE;
            end
          end
          ADDR_S: if (rise) begin
            sr_q  <= sr1_d;
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == 8'd23) begin
              cnt_q      <= '0;
              addr_q     <= sr1_d[ADDR_W-1:0];
              mem_addr_q <= sr1_d[ADDR_W-1:0];
              mem_rd_q   <= 1'b1;
              io_oe_q    <= 4'b0010;
              state_q    <= DATA_S;
            end
          end
          ADDR_Q: if (rise) begin
            sr_q  <= sr4_d;
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == 8'd5) begin
              cnt_q   <= '0;
              addr_q  <= sr4_d[ADDR_W-1:0];
              state_q <= MODE;
            end
          end
          MODE: if (rise) begin
            sr_q  <= sr4_d;
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == 8'd1) begin
              cnt_q  <= '0;
              cont_q <= (sr4_d[5:4] == 2'b10);
              if (DUMMY_CYCLES == 0) begin
                mem_addr_q <= addr_q;
                mem_rd_q   <= 1'b1;
                io_oe_q    <= 4'b1111;
                state_q    <= DATA_Q;
              end else begin
                state_q <= DUMMY;
              end
            end
          end
          DUMMY: if (rise) begin
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == DUMMY_LAST) begin
              cnt_q      <= '0;
              mem_addr_q <= addr_q;
              mem_rd_q   <= 1'b1;
              io_oe_q    <= 4'b1111;
              state_q    <= DATA_Q;
            end
          end
          // First beat of a byte loads from the prefetch buffer and fetches addr+1
          DATA_S: if (fall) begin
            cnt_q <= (cnt_q == 8'd7) ? 8'd0 : cnt_q + 8'd1;
            if (cnt_q == 8'd0) begin
              io_out_q   <= {2'b00, buf_q[7], 1'b0};
              sh_q       <= {buf_q[6:0], 1'b0};
              addr_q     <= addr_inc_d;
              mem_addr_q <= addr_inc_d;
              mem_rd_q   <= 1'b1;
            end else begin
              io_out_q <= {2'b00, sh_q[7], 1'b0};
              sh_q     <= {sh_q[6:0], 1'b0};
            end
          end
          DATA_Q: if (fall) begin
            if (cnt_q == 8'd0) begin
              cnt_q      <= 8'd1;
              io_out_q   <= buf_q[7:4];
              sh_q       <= {buf_q[3:0], 4'b0000};
              addr_q     <= addr_inc_d;
              mem_addr_q <= addr_inc_d;
              mem_rd_q   <= 1'b1;
            end else begin
              cnt_q    <= 8'd0;
              io_out_q <= sh_q[7:4];
            end
          end
          IGNORE: begin
            io_oe_q <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.io_out    = io_out_q;
  assign bus.io_oe     = io_oe_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.busy      = ~cs_s;
  assign bus.cont_mode = cont_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench for qspi_flash_responder: SPI master and byte memory whose
// content at each address equals the low address byte.
module tb_qspi_flash_responder;
  logic        clk = 1'b0;
  logic        reset;
  int          errors = 0;
  int          checks = 0;
  logic [3:0]  oe_acc = '0;
  logic [23:0] rd_addrs [$];
  logic [31:0] rx;

  qspi_flash_responder_if #(.ADDR_W(24)) bus ();

  qspi_flash_responder #(
    .ADDR_W(24), .DUMMY_CYCLES(4), .SYNC_STAGES(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_rd) begin
      bus.mem_rdata <= bus.mem_addr[7:0];
      rd_addrs.push_back(bus.mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sclk period: drive, sample just before the rise, rise, then fall
  task automatic beat(input logic [3:0] drv, output logic [3:0] smp);
    bus.io_in = drv;
    #80;
    smp = bus.io_out;
    oe_acc = oe_acc | bus.io_oe;
    bus.spi_sclk = 1'b1;
    #80;
    bus.spi_sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic [3:0] s;
    for (int i = n - 1; i >= 0; i--) beat({3'b000, v[i]}, s);
  endtask

  task automatic send_nibs(input logic [31:0] v, input int n);
    logic [3:0] s;
    for (int i = n - 1; i >= 0; i--) beat(v[4*i +: 4], s);
  endtask

  task automatic read_bits(input int n, output logic [31:0] v);
    logic [3:0] s;
    v = '0;
    for (int i = 0; i < n; i++) begin
      beat(4'h0, s);
      v = {v[30:0], s[1]};
    end
  endtask

  task automatic read_nibs(input int n, output logic [31:0] v);
    logic [3:0] s;
    v = '0;
    for (int i = 0; i < n; i++) begin
      beat(4'h0, s);
      v = {v[27:0], s};
    end
  endtask

  task automatic frame_start();
    rd_addrs.delete();
    bus.spi_cs_n = 1'b0;
    #80;
  endtask

  task automatic frame_end();
    bus.spi_cs_n = 1'b1;
    #160;
  endtask

  task automatic quad_hdr(input logic with_cmd, input logic [23:0] addr, input logic [7:0] m);
    if (with_cmd) send_bits(32'hEB, 8);
    send_nibs({8'h00, addr}, 6);
    send_nibs({24'h0, m}, 2);
    oe_acc = '0;
    send_nibs(32'h0, 4);
  endtask

  initial begin
    reset = 1'b0;
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b0;
    bus.io_in = 4'h1;

    // Reset held with an active-looking link
    for (int i = 0; i < 6; i++) begin
      #40;
      bus.spi_sclk = ~bus.spi_sclk;
      chk("rst_io_oe", {28'h0, bus.io_oe}, 32'h0);
      chk("rst_mem_rd", {31'h0, bus.mem_rd}, 32'h0);
      chk("rst_cont", {31'h0, bus.cont_mode}, 32'h0);
      chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    end
    chk("rst_io_out", {28'h0, bus.io_out}, 32'h0);
    chk("rst_mem_addr", {8'h0, bus.mem_addr}, 32'h0);
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.io_in = 4'h0;
    #40;
    reset = 1'b1;
    #100;

    // Single read 0x03 @ 0x55AACC
    frame_start();
    chk("busy_low_cs", {31'h0, bus.busy}, 32'h1);
    send_bits(32'h03, 8);
    send_bits(32'h55AACC, 24);
    oe_acc = '0;
    read_bits(16, rx);
    chk("single_data", rx, 32'h0000CCCD);
    chk("single_oe", {28'h0, oe_acc}, 32'h2);
    chk("single_nrd", {31'h0, rd_addrs.size() >= 2}, 32'h1);
    chk("single_addr0", {8'h0, rd_addrs[0]}, 32'h55AACC);
    chk("single_addr1", {8'h0, rd_addrs[1]}, 32'h55AACD);
    frame_end();
    chk("single_oe_off", {28'h0, bus.io_oe}, 32'h0);
    chk("single_busy_off", {31'h0, bus.busy}, 32'h0);

    // Quad read 0xEB @ 0x0000FE, M=0x00
    frame_start();
    quad_hdr(1'b1, 24'h0000FE, 8'h00);
    chk("quad_dummy_oe", {28'h0, oe_acc}, 32'h0);
    oe_acc = '0;
    read_nibs(8, rx);
    chk("quad_data", rx, 32'hFEFF0001);
    chk("quad_oe", {28'h0, oe_acc}, 32'hF);
    chk("quad_addr2", {8'h0, rd_addrs[2]}, 32'h000100);
    frame_end();
    chk("quad_cont", {31'h0, bus.cont_mode}, 32'h0);

    // Address wrap at the top of the space
    frame_start();
    quad_hdr(1'b1, 24'hFFFFFF, 8'h00);
    read_nibs(4, rx);
    chk("wrap_data", rx, 32'h0000FF00);
    chk("wrap_nrd", {31'h0, rd_addrs.size() >= 2}, 32'h1);
    chk("wrap_addr0", {8'h0, rd_addrs[0]}, 32'hFFFFFF);
    chk("wrap_addr1", {8'h0, rd_addrs[1]}, 32'h000000);
    frame_end();

    // Continuous-read mode armed by M=0x20, then a command-less frame
    frame_start();
    quad_hdr(1'b1, 24'h000040, 8'h20);
    read_nibs(2, rx);
    chk("cont_arm_data", rx, 32'h40);
    frame_end();
    chk("cont_armed", {31'h0, bus.cont_mode}, 32'h1);
    frame_start();
    quad_hdr(1'b0, 24'h000010, 8'hFF);
    read_nibs(2, rx);
    chk("cont_frame_data", rx, 32'h10);
    frame_end();
    chk("cont_cleared", {31'h0, bus.cont_mode}, 32'h0);

    // Abort mid-address, then mid-data
    frame_start();
    send_bits(32'h03, 8);
    send_bits(32'h0, 10);
    bus.spi_cs_n = 1'b1;
    #30;
    chk("abort_addr_oe", {28'h0, bus.io_oe}, 32'h0);
    chk("abort_addr_busy", {31'h0, bus.busy}, 32'h0);
    #130;
    frame_start();
    send_bits(32'h03, 8);
    send_bits(32'h0000A5, 24);
    oe_acc = '0;
    read_bits(4, rx);
    chk("abort_pre_data", rx, 32'hA);
    chk("abort_pre_oe", {28'h0, oe_acc}, 32'h2);
    bus.spi_cs_n = 1'b1;
    #30;
    chk("abort_data_oe", {28'h0, bus.io_oe}, 32'h0);
    #130;
    frame_start();
    send_bits(32'h03, 8);
    send_bits(32'h000033, 24);
    read_bits(8, rx);
    chk("after_abort_data", rx, 32'h33);
    frame_end();

    // Unknown command keeps every line tristated
    frame_start();
    send_bits(32'h9F, 8);
    oe_acc = '0;
    send_bits(32'h0, 16);
    chk("unknown_oe", {28'h0, oe_acc}, 32'h0);
    frame_end();

    // Reset asserted in the middle of DATA_Q with continuous mode armed
    frame_start();
    quad_hdr(1'b1, 24'h000077, 8'h20);
    read_nibs(2, rx);
    chk("pre_reset_data", rx, 32'h77);
    chk("pre_reset_cont", {31'h0, bus.cont_mode}, 32'h1);
    read_nibs(1, rx);
    reset = 1'b0;
    #20;
    chk("mid_rst_io_oe", {28'h0, bus.io_oe}, 32'h0);
    chk("mid_rst_io_out", {28'h0, bus.io_out}, 32'h0);
    chk("mid_rst_mem_rd", {31'h0, bus.mem_rd}, 32'h0);
    chk("mid_rst_mem_addr", {8'h0, bus.mem_addr}, 32'h0);
    chk("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("mid_rst_cont", {31'h0, bus.cont_mode}, 32'h0);
    bus.spi_cs_n = 1'b1;
    #40;
    reset = 1'b1;
    #100;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
